// File: rtl/anspwm_frame_seq.sv
// anspwm_frame_seq: frame sequencer and PWM generator for the ANS-PWM chain.
// Define ANSPWM_SAT_EN to clamp the corrected sum to 0..0xFFFF.
module anspwm_frame_seq #(
  parameter int NSTAGES  = 2,
  parameter int SETTLE   = 6,
  parameter int PWM_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [15:0]           in_data,
  output logic                  in_ready,
  output logic [15:0]           stg_a,
  input  logic [16*NSTAGES-1:0] c_mag,
  input  logic [NSTAGES-1:0]    c_sgn,
  output logic [15:0]           duty,
  output logic                  pwm_out,
  output logic                  frame_start,
  output logic                  underrun
);

`ifdef ANSPWM_SAT_EN
  localparam int SW = 16 + $clog2(NSTAGES) + 2;
`else
  // modulo-2^16 result is identical to truncating the wide sum
  localparam int SW = 16;
`endif
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [PWM_BITS-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SUM,
    ST_WAIT
  } state_t;

  state_t state, state_n;

  logic [PWM_BITS-1:0] cnt;
  logic [CW-1:0]       scnt, scnt_n;
  logic [15:0]         base;
  logic [15:0]         duty_next;
  logic [15:0]         sum_clip;
  logic [SW-1:0]       sum;
  logic                ready_flag;
  logic                wrap;
  logic                accept;
  logic                publish;

  assign wrap = (cnt == CMAX);

  always_comb begin
    state_n = state;
    scnt_n  = scnt;
    accept  = 1'b0;
    publish = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          accept  = 1'b1;
          scnt_n  = CW'(SETTLE - 1);
          state_n = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (scnt == '0) state_n = ST_SUM;
        else scnt_n = scnt - 1'b1;
      end
      ST_SUM: begin
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (wrap && ready_flag) begin
          publish = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // base plus signed stage corrections, two's complement in SW bits
  always_comb begin
    sum = SW'(base);
    for (int i = 0; i < NSTAGES; i++) begin
      if (c_sgn[i]) sum = sum - SW'(c_mag[16*i +: 16]);
      else          sum = sum + SW'(c_mag[16*i +: 16]);
    end
  end

`ifdef ANSPWM_SAT_EN
  always_comb begin
    sum_clip = sum[15:0];
    if (sum[SW-1])          sum_clip = 16'h0000;
    else if (|sum[SW-2:16]) sum_clip = 16'hFFFF;
  end
`else
  assign sum_clip = sum[15:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      scnt       <= '0;
      in_ready   <= 1'b0;
      stg_a      <= '0;
      base       <= '0;
      duty_next  <= '0;
      ready_flag <= 1'b0;
      duty       <= '0;
    end else begin
      state    <= state_n;
      scnt     <= scnt_n;
      in_ready <= (state_n == ST_IDLE);
      if (accept) begin
        base  <= in_data;
        stg_a <= in_data;
      end
      if (state == ST_SUM) begin
        duty_next  <= sum_clip;
        ready_flag <= 1'b1;
      end
      if (publish) begin
        duty       <= duty_next;
        ready_flag <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      pwm_out     <= 1'b0;
    end else begin
      cnt         <= cnt + 1'b1;
      frame_start <= wrap;
      underrun    <= wrap && (state != ST_WAIT);
      pwm_out     <= (cnt < duty[15 -: PWM_BITS]);
    end
  end

endmodule
